// File: rtl/bank_decoder_pkg.sv
// bank_decoder_pkg
// Shared constants and types for the 8096-style bank decoder.
//   - Bit positions inside the bank-control register.
//   - Bit positions inside the one-hot io_select vector.
//   - The region classification enum.
//   - A helper that builds the 17-bit SRAM address for an expanded access.
// Optional feature macro used by the design files: PEEK_THROUGH_EN.
package bank_decoder_pkg;

  // Bank-control register bit positions. Bit 4 is stored but has no effect.
  localparam int CTRL_EXP      = 7;
  localparam int CTRL_IO_PEEK  = 6;
  localparam int CTRL_SCR_PEEK = 5;
  localparam int CTRL_BANK_HI  = 3;
  localparam int CTRL_BANK_LO  = 2;
  localparam int CTRL_WP_HI    = 1;
  localparam int CTRL_WP_LO    = 0;

  // One-hot io_select bit positions.
  localparam int IO_SEL_PIA1 = 0;
  localparam int IO_SEL_PIA2 = 1;
  localparam int IO_SEL_VIA  = 2;
  localparam int IO_SEL_CRTC = 3;
  localparam int IO_SEL_W    = 4;

  typedef enum logic [2:0] {
    REGION_RAM   = 3'd0,
    REGION_VRAM  = 3'd1,
    REGION_MAGIC = 3'd2,
    REGION_IO    = 3'd3,
    REGION_ROM   = 3'd4,
    REGION_EXP   = 3'd5
  } region_e;

  // Expanded SRAM address: upper 64 KB half, addr[14] picks the 16 KB
  // window, and the per-window bank bit picks which of two 16 KB pages.
  function automatic logic [16:0] exp_ram_addr(input logic [14:0] low_addr,
                                               input logic        bank_hi,
                                               input logic        bank_lo);
    logic bank_sel;
    bank_sel = low_addr[14] ? bank_hi : bank_lo;
    return {1'b1, low_addr[14], bank_sel, low_addr[13:0]};
  endfunction

endpackage

// File: rtl/bank_region_classify.sv
// bank_region_classify
// Combinational classifier: decides which region a CPU address falls in
// given the expansion and peek-through enables taken from the bank register.
// Ports:
//   addr          in  16  CPU address
//   exp_en        in  1   expansion enable (control bit 7)
//   io_peek_en    in  1   I/O peek-through enable (0 when PEEK_THROUGH_EN undefined)
//   scr_peek_en   in  1   screen peek-through enable (0 when PEEK_THROUGH_EN undefined)
//   region        out     region_e classification
//   io_select     out 4   one-hot I/O chip select, valid when region == REGION_IO
module bank_region_classify
  import bank_decoder_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = 16'hE800,
  parameter int          VRAM_BYTES = 4096
) (
  input  logic [15:0]         addr,
  input  logic                exp_en,
  input  logic                io_peek_en,
  input  logic                scr_peek_en,
  output region_e             region,
  output logic [IO_SEL_W-1:0] io_select
);

  localparam logic [15:0] VRAM_END = 16'(32'h8000 + VRAM_BYTES - 1);

  logic       io_peek;
  logic       scr_peek;
  logic       expand;
  logic       in_io_window;
  logic [7:0] io_offset;

  // I/O peek-through punches the whole 2 KB page holding the I/O window
  // ($E800-$EFFF by default) back to the normal map; screen peek-through
  // does the same for $8000-$8FFF.
  assign io_peek  = io_peek_en  && (addr[15:11] == IO_BASE[15:11]);
  assign scr_peek = scr_peek_en && (addr[15:12] == 4'h8);
  assign expand   = exp_en && addr[15] && !io_peek && !scr_peek;

  assign in_io_window = (addr[15:8] == IO_BASE[15:8]);
  assign io_offset    = addr[7:0];

  always_comb begin
    region    = REGION_ROM;
    io_select = '0;
    if (expand) begin
      region = REGION_EXP;
    end else if (!addr[15]) begin
      region = REGION_RAM;
    end else if (addr <= VRAM_END) begin
      region = REGION_VRAM;
    end else if (in_io_window) begin
      if (io_offset[7:4] == 4'h0) begin
        region = REGION_MAGIC;
      end else begin
        region = REGION_IO;
        // Slots are power-of-two sized and aligned, so the highest set
        // offset bit identifies the chip.
        if (io_offset[7])      io_select[IO_SEL_CRTC] = 1'b1;
        else if (io_offset[6]) io_select[IO_SEL_VIA]  = 1'b1;
        else if (io_offset[5]) io_select[IO_SEL_PIA2] = 1'b1;
        else                   io_select[IO_SEL_PIA1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_decoder.sv
// bank_decoder
// Registered 6502 address decoder with an 8096-style bank-control register.
// Maps the 64 KB CPU space onto a 128 KB SRAM and drives I/O chip selects.
// Optional feature macro: PEEK_THROUGH_EN (I/O and screen peek-through).
// Ports:
//   clk           in  1   system clock, rising edge
//   reset_b       in  1   asynchronous active-low reset
//   addr          in  16  CPU address
//   rw_b          in  1   1 = read, 0 = write
//   strobe        in  1   valid bus cycle pulse (qualifies register writes only)
//   data_in       in  8   CPU write data
//   ram_addr      out 17  registered SRAM address
//   ram_enable    out 1   SRAM access
//   io_enable     out 1   any I/O chip selected
//   io_select     out 4   one-hot PIA1/PIA2/VIA/CRTC
//   mirror_enable out 1   access lands in VRAM
//   write_enable  out 1   write permitted this cycle
//   bank_reg      out 8   bank-control register
module bank_decoder
  import bank_decoder_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = 16'hE800,
  parameter int          VRAM_BYTES = 4096,
  parameter logic [15:0] CTRL_ADDR  = 16'hFFF0
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [15:0]         addr,
  input  logic                rw_b,
  input  logic                strobe,
  input  logic [7:0]          data_in,
  output logic [16:0]         ram_addr,
  output logic                ram_enable,
  output logic                io_enable,
  output logic [IO_SEL_W-1:0] io_select,
  output logic                mirror_enable,
  output logic                write_enable,
  output logic [7:0]          bank_reg
);

  logic                ctrl_wr;
  logic [7:0]          bank_reg_next;
  logic                io_peek_en;
  logic                scr_peek_en;
  region_e             region;
  logic [IO_SEL_W-1:0] slot_select;

  logic [16:0]         ram_addr_next;
  logic                ram_enable_next;
  logic                io_enable_next;
  logic [IO_SEL_W-1:0] io_select_next;
  logic                mirror_enable_next;
  logic                write_enable_next;
  logic                writable;

  assign ctrl_wr = strobe && !rw_b && (addr == CTRL_ADDR);

`ifdef PEEK_THROUGH_EN
  assign io_peek_en  = bank_reg[CTRL_IO_PEEK];
  assign scr_peek_en = bank_reg[CTRL_SCR_PEEK];
`else
  assign io_peek_en  = 1'b0;
  assign scr_peek_en = 1'b0;
`endif

  always_comb begin
    bank_reg_next = data_in;
`ifndef PEEK_THROUGH_EN
    // Peek-through bits do not exist in this build and always read as 0.
    bank_reg_next[CTRL_IO_PEEK]  = 1'b0;
    bank_reg_next[CTRL_SCR_PEEK] = 1'b0;
`endif
  end

  // Classification uses the register value before any write in this same
  // cycle; the new value takes effect on the following decode.
  bank_region_classify #(
    .IO_BASE   (IO_BASE),
    .VRAM_BYTES(VRAM_BYTES)
  ) u_classify (
    .addr       (addr),
    .exp_en     (bank_reg[CTRL_EXP]),
    .io_peek_en (io_peek_en),
    .scr_peek_en(scr_peek_en),
    .region     (region),
    .io_select  (slot_select)
  );

  always_comb begin
    ram_addr_next      = {1'b0, addr};
    ram_enable_next    = 1'b0;
    io_enable_next     = 1'b0;
    io_select_next     = '0;
    mirror_enable_next = 1'b0;
    writable           = 1'b0;
    case (region)
      REGION_RAM, REGION_MAGIC: begin
        ram_enable_next = 1'b1;
        writable        = 1'b1;
      end
      REGION_VRAM: begin
        ram_enable_next    = 1'b1;
        mirror_enable_next = 1'b1;
        writable           = 1'b1;
      end
      REGION_IO: begin
        io_enable_next = 1'b1;
        io_select_next = slot_select;
        writable       = 1'b1;
      end
      REGION_EXP: begin
        ram_addr_next   = exp_ram_addr(addr[14:0], bank_reg[CTRL_BANK_HI],
                                       bank_reg[CTRL_BANK_LO]);
        ram_enable_next = 1'b1;
        writable        = addr[14] ? !bank_reg[CTRL_WP_HI] : !bank_reg[CTRL_WP_LO];
      end
      default: begin
        // ROM
        ram_enable_next = 1'b1;
      end
    endcase
    write_enable_next = !rw_b && writable;
    // A control-register write is not a memory or I/O access.
    if (ctrl_wr) begin
      ram_enable_next    = 1'b0;
      io_enable_next     = 1'b0;
      io_select_next     = '0;
      mirror_enable_next = 1'b0;
      write_enable_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bank_reg      <= 8'h00;
      ram_addr      <= '0;
      ram_enable    <= 1'b0;
      io_enable     <= 1'b0;
      io_select     <= '0;
      mirror_enable <= 1'b0;
      write_enable  <= 1'b0;
    end else begin
      if (ctrl_wr) bank_reg <= bank_reg_next;
      ram_addr      <= ram_addr_next;
      ram_enable    <= ram_enable_next;
      io_enable     <= io_enable_next;
      io_select     <= io_select_next;
      mirror_enable <= mirror_enable_next;
      write_enable  <= write_enable_next;
    end
  end

endmodule
